resettable_scoreboard_register_file: RTL and testbench
======================================================

RESETTABLE_SCOREBOARD_REGISTER_FILE -- requirements
Module: resettable_scoreboard_register_file

Interface
REQ-001 The block SHALL have parameter N, default 32, data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, register address width, minimum 5; depth = 2^ADDR_W.
REQ-003 The block SHALL have parameter SP_INIT, default 32'h7FFF_EFFC, reset value of register 29 ($sp).
REQ-004 The block SHALL have parameter GP_INIT, default 32'h1000_8000, reset value of register 28 ($gp).
REQ-005 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 The block SHALL have port RegWrite  input  1  write enable.
REQ-008 The block SHALL have port in_WriteRegister  input  ADDR_W  write address.
REQ-009 The block SHALL have port in_WriteData  input  N  write data.
REQ-010 The block SHALL have port in_ReadRegister1  input  ADDR_W  read port 1 address.
REQ-011 The block SHALL have port in_ReadRegister2  input  ADDR_W  read port 2 address.
REQ-012 The block SHALL have port Reserve  input  1  mark a destination register as pending.
REQ-013 The block SHALL have port in_ReserveRegister  input  ADDR_W  register to mark pending.
REQ-014 The block SHALL have port o_ReadData1  output  N  read port 1 data.
REQ-015 The block SHALL have port o_ReadData2  output  N  read port 2 data.
REQ-016 The block SHALL have port o_Busy1  output  1  read port 1 register pending.
REQ-017 The block SHALL have port o_Busy2  output  1  read port 2 register pending.

Function
REQ-018 Storage SHALL be 2^ADDR_W registers of N bits plus one busy bit per register.
REQ-019 Write: at rising clk with reset=1, RegWrite=1 and in_WriteRegister!=0, the register SHALL take in_WriteData; no other register changes.
REQ-020 Register 0 SHALL never be written and SHALL always read 0; its busy bit SHALL always be 0.
REQ-021 Reads SHALL be combinational, zero latency.
REQ-022 Bypass: when RegWrite=1, in_WriteRegister==read address and address!=0, that port SHALL output in_WriteData in the same cycle instead of the stored value.
REQ-023 Both read ports SHALL be independent; identical addresses SHALL return identical data.
REQ-024 Reserve: at rising clk with reset=1, Reserve=1 and in_ReserveRegister!=0, that busy bit SHALL be set to 1.
REQ-025 A qualifying write (REQ-019) SHALL clear the busy bit of in_WriteRegister.
REQ-026 If Reserve and RegWrite target the same register in the same cycle, the busy bit SHALL end at 1 (reserve wins) and the data SHALL still be written.
REQ-027 Reserving an already-busy register SHALL leave it busy; writing a non-busy register SHALL leave it non-busy.
REQ-028 o_BusyX SHALL equal busy[addrX] AND NOT (RegWrite AND in_WriteRegister==addrX), i.e. a same-cycle write makes the bypassed data valid.
REQ-029 Address compares SHALL use all ADDR_W bits; no wrap or truncation.

Reset
REQ-030 At rising clk with reset=0, all registers SHALL become 0 except register 28 = GP_INIT and register 29 = SP_INIT.
REQ-031 At rising clk with reset=0, all busy bits SHALL become 0.
REQ-032 Reset SHALL take priority over RegWrite and Reserve in the same cycle; both are ignored.
REQ-033 During reset (reset=0) outputs SHALL remain combinational over current state; after the reset edge o_ReadData = 0 / init values, o_Busy = 0.

Verification
REQ-034 Reset, then read addr 29 and 28, addr 5 -> o_ReadData1=32'h7FFF_EFFC, o_ReadData2=32'h1000_8000, then 0 for addr 5, o_Busy1=o_Busy2=0.
REQ-035 RegWrite=1, addr 0, data 32'hDEAD_BEEF; read addr 0 same and next cycle -> 0 both cycles.
REQ-036 RegWrite=1, addr 8, data 32'h1234_5678, read1=8 same cycle -> o_ReadData1=32'h1234_5678 (bypass); next cycle with RegWrite=0 -> still 32'h1234_5678.
REQ-037 Reserve addr 9; next cycle read2=9 -> o_Busy2=1; RegWrite addr 9 data 32'hA5 -> o_Busy2=0 and o_ReadData2=32'hA5 that cycle; next cycle o_Busy2=0.
REQ-038 Reserve and RegWrite both addr 10 data 32'h77 in one cycle -> next cycle o_ReadData1=32'h77, o_Busy1=1.
REQ-039 With reg 8 busy and holding 32'h1234_5678, assert reset=0 with RegWrite addr 8 data 32'hFFFF_FFFF -> next cycle reg 8 reads 0, o_Busy=0.

Source files
------------

// File: rtl/resettable_scoreboard_register_file.sv
// Register file with per-register pending (busy) bits for a scoreboarded pipeline.
// Two combinational read ports with same-cycle write bypass; synchronous active-low reset.
module resettable_scoreboard_register_file #(
    parameter int unsigned N       = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter logic [31:0] SP_INIT = 32'h7FFF_EFFC,
    parameter logic [31:0] GP_INIT = 32'h1000_8000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] in_WriteRegister,
    input  logic [N-1:0]      in_WriteData,
    input  logic [ADDR_W-1:0] in_ReadRegister1,
    input  logic [ADDR_W-1:0] in_ReadRegister2,
    input  logic              Reserve,
    input  logic [ADDR_W-1:0] in_ReserveRegister,
    output logic [N-1:0]      o_ReadData1,
    output logic [N-1:0]      o_ReadData2,
    output logic              o_Busy1,
    output logic              o_Busy2
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned GP_REG = 28;
    localparam int unsigned SP_REG = 29;

    logic [N-1:0]     regFile [DEPTH];
    logic [DEPTH-1:0] busy;

    logic writeValid;
    logic reserveValid;
    logic writeHit1;
    logic writeHit2;

    assign writeValid   = RegWrite && (in_WriteRegister != '0);
    assign reserveValid = Reserve && (in_ReserveRegister != '0);

    // Storage and scoreboard update; a reserve issued with a write to the same register wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (i == int'(GP_REG)) begin
                    regFile[i] <= N'(GP_INIT);
                end else if (i == int'(SP_REG)) begin
                    regFile[i] <= N'(SP_INIT);
                end else begin
                    regFile[i] <= '0;
                end
            end
            busy <= '0;
        end else begin
            if (writeValid) begin
                regFile[in_WriteRegister] <= in_WriteData;
                busy[in_WriteRegister]    <= 1'b0;
            end
            if (reserveValid) begin
                busy[in_ReserveRegister] <= 1'b1;
            end
        end
    end

    assign writeHit1 = RegWrite && (in_WriteRegister == in_ReadRegister1);
    assign writeHit2 = RegWrite && (in_WriteRegister == in_ReadRegister2);

    // Read ports: register 0 is hardwired to zero, otherwise bypass an in-flight write.
    always_comb begin
        o_ReadData1 = '0;
        o_Busy1     = 1'b0;
        if (in_ReadRegister1 != '0) begin
            o_ReadData1 = writeHit1 ? in_WriteData : regFile[in_ReadRegister1];
            o_Busy1     = busy[in_ReadRegister1] && !writeHit1;
        end
    end

    always_comb begin
        o_ReadData2 = '0;
        o_Busy2     = 1'b0;
        if (in_ReadRegister2 != '0) begin
            o_ReadData2 = writeHit2 ? in_WriteData : regFile[in_ReadRegister2];
            o_Busy2     = busy[in_ReadRegister2] && !writeHit2;
        end
    end

endmodule

// File: tb/tb_resettable_scoreboard_register_file.sv
// Bench for resettable_scoreboard_register_file: directed scenarios plus random traffic
// compared against an array-based reference model of the register file and its pending bits.
module tb_resettable_scoreboard_register_file;

    localparam int unsigned N      = 32;
    localparam int unsigned ADDR_W = 5;

    logic              clk;
    logic              reset;
    logic              RegWrite;
    logic [ADDR_W-1:0] in_WriteRegister;
    logic [N-1:0]      in_WriteData;
    logic [ADDR_W-1:0] in_ReadRegister1;
    logic [ADDR_W-1:0] in_ReadRegister2;
    logic              Reserve;
    logic [ADDR_W-1:0] in_ReserveRegister;
    logic [N-1:0]      o_ReadData1;
    logic [N-1:0]      o_ReadData2;
    logic              o_Busy1;
    logic              o_Busy2;

    int errorCount = 0;
    int checkCount = 0;

    logic [31:0] refData [32];
    bit          refBusy [32];

    resettable_scoreboard_register_file dut (
        .clk                (clk),
        .reset              (reset),
        .RegWrite           (RegWrite),
        .in_WriteRegister   (in_WriteRegister),
        .in_WriteData       (in_WriteData),
        .in_ReadRegister1   (in_ReadRegister1),
        .in_ReadRegister2   (in_ReadRegister2),
        .Reserve            (Reserve),
        .in_ReserveRegister (in_ReserveRegister),
        .o_ReadData1        (o_ReadData1),
        .o_ReadData2        (o_ReadData2),
        .o_Busy1            (o_Busy1),
        .o_Busy2            (o_Busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input bit we, input int wa, input logic [31:0] wd,
                         input int ra1, input int ra2, input bit rs, input int rr);
        reset              = ~rst;
        RegWrite           = we;
        in_WriteRegister   = ADDR_W'(wa);
        in_WriteData       = wd;
        in_ReadRegister1   = ADDR_W'(ra1);
        in_ReadRegister2   = ADDR_W'(ra2);
        Reserve            = rs;
        in_ReserveRegister = ADDR_W'(rr);
    endtask

    function automatic logic [31:0] expData(input int a);
        if (a == 0) return 32'h0;
        if (RegWrite && int'(in_WriteRegister) == a) return in_WriteData;
        return refData[a];
    endfunction

    function automatic bit expBusy(input int a);
        if (a == 0) return 1'b0;
        return refBusy[a] && !(RegWrite && int'(in_WriteRegister) == a);
    endfunction

    // Compare all outputs against the model for the inputs currently applied.
    task automatic checkAll(input string tag);
        checkVal({tag, ".rd1"}, o_ReadData1, expData(int'(in_ReadRegister1)));
        checkVal({tag, ".rd2"}, o_ReadData2, expData(int'(in_ReadRegister2)));
        checkVal({tag, ".bz1"}, 32'(o_Busy1), 32'(expBusy(int'(in_ReadRegister1))));
        checkVal({tag, ".bz2"}, 32'(o_Busy2), 32'(expBusy(int'(in_ReadRegister2))));
    endtask

    // Advance one clock and apply the architectural update rules to the model.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                refData[i] = 32'h0;
                refBusy[i] = 1'b0;
            end
            refData[28] = 32'h1000_8000;
            refData[29] = 32'h7FFF_EFFC;
        end else begin
            if (RegWrite && in_WriteRegister != 0) begin
                refData[int'(in_WriteRegister)] = in_WriteData;
                refBusy[int'(in_WriteRegister)] = 1'b0;
            end
            if (Reserve && in_ReserveRegister != 0) refBusy[int'(in_ReserveRegister)] = 1'b1;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            refData[i] = 32'h0;
            refBusy[i] = 1'b0;
        end
        drive(1, 1, 3, 32'hCAFE_0000, 0, 0, 1, 3);
        tick();
        tick();

        // Reset values of $sp, $gp and an ordinary register
        drive(0, 0, 0, 0, 29, 28, 0, 0);
        @(negedge clk);
        checkVal("rst.sp", o_ReadData1, 32'h7FFF_EFFC);
        checkVal("rst.gp", o_ReadData2, 32'h1000_8000);
        checkVal("rst.bz1", 32'(o_Busy1), 32'h0);
        checkVal("rst.bz2", 32'(o_Busy2), 32'h0);
        tick();
        drive(0, 0, 0, 0, 5, 3, 0, 0);
        @(negedge clk);
        checkVal("rst.r5", o_ReadData1, 32'h0);
        checkVal("rst.r3", o_ReadData2, 32'h0);
        checkVal("rst.bz3", 32'(o_Busy2), 32'h0);
        tick();

        // Register 0 ignores writes
        drive(0, 1, 0, 32'hDEAD_BEEF, 0, 0, 1, 0);
        @(negedge clk);
        checkVal("r0.same", o_ReadData1, 32'h0);
        checkVal("r0.bz", 32'(o_Busy1), 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkVal("r0.next", o_ReadData2, 32'h0);
        tick();

        // Same-cycle bypass then stored value
        drive(0, 1, 8, 32'h1234_5678, 8, 7, 0, 0);
        @(negedge clk);
        checkVal("byp.same", o_ReadData1, 32'h1234_5678);
        checkVal("byp.other", o_ReadData2, 32'h0);
        tick();
        drive(0, 0, 8, 32'h0, 8, 8, 0, 0);
        @(negedge clk);
        checkVal("byp.next1", o_ReadData1, 32'h1234_5678);
        checkVal("byp.next2", o_ReadData2, 32'h1234_5678);
        tick();

        // Reserve then resolving write
        drive(0, 0, 0, 0, 1, 9, 1, 9);
        @(negedge clk);
        checkVal("rsv.pre", 32'(o_Busy2), 32'h0);
        tick();
        drive(0, 0, 0, 0, 1, 9, 0, 0);
        @(negedge clk);
        checkVal("rsv.busy", 32'(o_Busy2), 32'h1);
        tick();
        drive(0, 1, 9, 32'hA5, 1, 9, 0, 0);
        @(negedge clk);
        checkVal("rsv.wbz", 32'(o_Busy2), 32'h0);
        checkVal("rsv.wdat", o_ReadData2, 32'hA5);
        tick();
        drive(0, 0, 0, 0, 1, 9, 0, 0);
        @(negedge clk);
        checkVal("rsv.after", 32'(o_Busy2), 32'h0);
        tick();

        // Reserve and write to the same register: reserve wins, data still lands
        drive(0, 1, 10, 32'h77, 2, 2, 1, 10);
        tick();
        drive(0, 0, 0, 0, 10, 10, 0, 0);
        @(negedge clk);
        checkVal("rw.dat", o_ReadData1, 32'h77);
        checkVal("rw.bz", 32'(o_Busy1), 32'h1);
        tick();

        // Reset beats a concurrent write to a busy register
        drive(0, 0, 0, 0, 0, 0, 1, 8);
        tick();
        drive(0, 0, 0, 0, 8, 8, 0, 0);
        @(negedge clk);
        checkVal("rp.busy", 32'(o_Busy1), 32'h1);
        tick();
        drive(1, 1, 8, 32'hFFFF_FFFF, 8, 8, 1, 8);
        tick();
        drive(0, 0, 0, 0, 8, 10, 0, 0);
        @(negedge clk);
        checkVal("rp.dat", o_ReadData1, 32'h0);
        checkVal("rp.bz1", 32'(o_Busy1), 32'h0);
        checkVal("rp.bz2", 32'(o_Busy2), 32'h0);
        tick();

        // Random traffic, addresses biased toward a small window to provoke collisions
        for (int c = 0; c < 600; c++) begin
            int  lo;
            int  hi;
            bit  rst;
            lo  = ($urandom_range(0, 3) == 0) ? 0 : 24;
            hi  = lo + 7;
            rst = ($urandom_range(0, 49) == 0);
            drive(rst, ($urandom_range(0, 1) == 1), $urandom_range(lo, hi), $urandom,
                  $urandom_range(lo, hi), $urandom_range(lo, hi),
                  ($urandom_range(0, 2) == 0), $urandom_range(lo, hi));
            @(negedge clk);
            checkAll("rnd");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
